// File: rtl/div_ctrl.sv
// div_ctrl: programmable clock-enable divider with staged reconfiguration.
//
// Emits a registered one-cycle tick once every div_active cycles while running.
// A new divide value offered during a period is staged and applied at the
// period boundary, so a period in progress always completes with its old value.
//
// Ports:
//   clk_in      - single clock, rising edge
//   reset_n     - synchronous active-low reset
//   start/stop  - one-cycle run/halt requests (stop wins when both are high)
//   cfg_valid   - divide value offered on cfg_div
//   cfg_div     - offered divide value (zero is rejected)
//   cfg_ready   - a divide value can be accepted this cycle
//   cfg_err     - one-cycle pulse after a zero divide value was rejected
//   tick        - one-cycle enable pulse per divide period
//   busy        - high whenever the block is not IDLE
//   div_active  - divide value currently in force
//   tick_count  - running tick count (only with DIV_CTRL_TICK_COUNT_EN)
//
// Optional feature macro: DIV_CTRL_TICK_COUNT_EN adds the 32-bit tick_count output.
module div_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] div_active
`ifdef DIV_CTRL_TICK_COUNT_EN
    ,
    output logic [31:0]      tick_count
`endif
);

    localparam int unsigned TC_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] stage_q, stage_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic xfer, xfer_ok, xfer_zero, terminal;

    // Ready is forced low during reset, so it cannot be a plain flop output.
    assign cfg_ready = reset_n && (state_q != PEND);
    assign xfer      = cfg_valid && cfg_ready;
    assign xfer_ok   = xfer && (cfg_div != '0);
    assign xfer_zero = xfer && (cfg_div == '0);
    assign terminal  = (cnt_q == (div_q - CNT_W'(1)));

    // Next-state, counter, divide value and tick computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        stage_d = stage_q;
        tick_d  = 1'b0;
        err_d   = xfer_zero;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer_ok) div_d = cfg_div;
                if (start && !stop) state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (xfer_ok) div_d = cfg_div;
                end else if (terminal) begin
                    // Boundary: a value arriving now governs the next period.
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (xfer_ok) div_d = cfg_div;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (xfer_ok) begin
                        stage_d = cfg_div;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    div_d   = stage_q;
                    stage_d = '0;
                end else if (terminal) begin
                    // Old period completes with its tick; staged value takes over.
                    state_d = RUN;
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    div_d   = stage_q;
                    stage_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= CNT_W'(DEFAULT_DIV);
            stage_q <= '0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            stage_q <= stage_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign tick       = tick_q;
    assign cfg_err    = err_q;
    assign busy       = (state_q != IDLE);
    assign div_active = div_q;

`ifdef DIV_CTRL_TICK_COUNT_EN
    logic [TC_W-1:0] tc_q, tc_d;

    // Tick counter: cleared by a start from IDLE, wraps naturally.
    always_comb begin
        tc_d = tc_q;
        if (state_q == IDLE && start && !stop) tc_d = '0;
        else if (tick_d)                       tc_d = tc_q + TC_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) tc_q <= '0;
        else          tc_q <= tc_d;
    end

    assign tick_count = tc_q;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl (CNT_W=16, DEFAULT_DIV=2).
module tb_div_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             reset_n;
    logic             start, stop, cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready, cfg_err, tick, busy;
    logic [CNT_W-1:0] div_active;
`ifdef DIV_CTRL_TICK_COUNT_EN
    logic [31:0]      tick_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(2)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .tick       (tick),
        .busy       (busy),
        .div_active (div_active)
`ifdef DIV_CTRL_TICK_COUNT_EN
        ,
        .tick_count (tick_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        start;
        logic        stop;
        logic        cfg_valid;
        logic [15:0] cfg_div;
        logic        tick;
        logic        busy;
        logic        ready;
        logic        err;
        logic [15:0] div;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; cfg_valid = 0; cfg_div = '0;
    endtask

    // Steps until tick is seen; returns edges taken (max on timeout).
    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < max);
    endtask

    int n, tot;

    initial begin
        // inputs, then expected tick busy ready err div after the edge
        vecs[0]  = '{0,0,0,16'd0, 0,0,1,0,16'd2};
        vecs[1]  = '{0,0,1,16'd0, 0,0,1,1,16'd2}; // zero cfg in IDLE
        vecs[2]  = '{0,0,0,16'd0, 0,0,1,0,16'd2};
        vecs[3]  = '{1,0,0,16'd0, 0,1,1,0,16'd2}; // start
        vecs[4]  = '{0,0,0,16'd0, 0,1,1,0,16'd2};
        vecs[5]  = '{0,0,0,16'd0, 1,1,1,0,16'd2}; // tick 2 after start
        vecs[6]  = '{0,0,0,16'd0, 0,1,1,0,16'd2};
        vecs[7]  = '{0,0,0,16'd0, 1,1,1,0,16'd2};
        vecs[8]  = '{0,0,0,16'd0, 0,1,1,0,16'd2};
        vecs[9]  = '{0,0,1,16'd0, 1,1,1,1,16'd2}; // zero cfg in RUN
        vecs[10] = '{0,0,0,16'd0, 0,1,1,0,16'd2};
        vecs[11] = '{0,0,0,16'd0, 1,1,1,0,16'd2};
        vecs[12] = '{0,1,0,16'd0, 0,0,1,0,16'd2}; // stop
        vecs[13] = '{0,0,0,16'd0, 0,0,1,0,16'd2};
        vecs[14] = '{0,0,1,16'd5, 0,0,1,0,16'd5}; // legal cfg in IDLE

        idle_inputs();
        reset_n = 0;
        step(); step(); step();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_ready_low", 32'(cfg_ready), 0);
        chk("rst_div", 32'(div_active), 2);
`ifdef DIV_CTRL_TICK_COUNT_EN
        chk("rst_tcount", tick_count, 0);
`endif
        reset_n = 1;
        #1;
        chk("rel_ready", 32'(cfg_ready), 1);

        for (int i = 0; i < 15; i++) begin
            start = vecs[i].start; stop = vecs[i].stop;
            cfg_valid = vecs[i].cfg_valid; cfg_div = vecs[i].cfg_div;
            step();
            chk($sformatf("v%0d_tick", i), 32'(tick), 32'(vecs[i].tick));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_ready", i), 32'(cfg_ready), 32'(vecs[i].ready));
            chk($sformatf("v%0d_err", i), 32'(cfg_err), 32'(vecs[i].err));
            chk($sformatf("v%0d_div", i), 32'(div_active), 32'(vecs[i].div));
        end
        idle_inputs();

        // Div 5 running, stage 3 at counter 1.
        start = 1; step(); start = 0;
        wait_tick(20, n);
        chk("a_first5", n, 5);
        step();
        cfg_valid = 1; cfg_div = 16'd3;
        #1;
        chk("a_ready_run", 32'(cfg_ready), 1);
        step();
        idle_inputs();
        chk("a_ready_pend", 32'(cfg_ready), 0);
        chk("a_div_pend", 32'(div_active), 5);
        tot = 2;
        wait_tick(20, n);
        chk("a_old_period", tot + n, 5);
        chk("a_div_new", 32'(div_active), 3);
        chk("a_ready_back", 32'(cfg_ready), 1);
        wait_tick(20, n);
        chk("a_new_period", n, 3);
        stop = 1; step(); stop = 0;

        // Div 1: tick continuously high, stop drops it.
        cfg_valid = 1; cfg_div = 16'd1; start = 1;
        step();
        idle_inputs();
        chk("b_div1", 32'(div_active), 1);
        chk("b_tick0", 32'(tick), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("b_tick_hi%0d", i), 32'(tick), 1);
        end
        stop = 1; step(); stop = 0;
        chk("b_stop_tick", 32'(tick), 0);
        chk("b_stop_busy", 32'(busy), 0);

        // Stop while PEND holding 7.
        cfg_valid = 1; cfg_div = 16'd4; start = 1;
        step();
        idle_inputs();
        step();
        cfg_valid = 1; cfg_div = 16'd7;
        step();
        idle_inputs();
        chk("c_pend_ready", 32'(cfg_ready), 0);
        chk("c_pend_div", 32'(div_active), 4);
        stop = 1; step(); stop = 0;
        chk("c_stop_tick", 32'(tick), 0);
        chk("c_stop_busy", 32'(busy), 0);
        chk("c_stop_div", 32'(div_active), 7);
        start = 1; step(); start = 0;
        wait_tick(20, n);
        chk("c_first7", n, 7);
        stop = 1; step(); stop = 0;

        // Reset mid-period with div 4 and staged 9.
        cfg_valid = 1; cfg_div = 16'd4; start = 1;
        step();
        idle_inputs();
        step();
        cfg_valid = 1; cfg_div = 16'd9;
        step();
        idle_inputs();
        reset_n = 0;
        step();
        chk("d_rst_tick", 32'(tick), 0);
        chk("d_rst_busy", 32'(busy), 0);
        chk("d_rst_ready", 32'(cfg_ready), 0);
        chk("d_rst_err", 32'(cfg_err), 0);
        chk("d_rst_div", 32'(div_active), 2);
`ifdef DIV_CTRL_TICK_COUNT_EN
        chk("d_rst_tcount", tick_count, 0);
`endif
        reset_n = 1;
        #1;
        chk("d_rel_ready", 32'(cfg_ready), 1);
        start = 1; step(); start = 0;
        wait_tick(20, n);
        chk("d_first2", n, 2);
        for (int i = 0; i < 9; i++) begin
            wait_tick(20, n);
            chk($sformatf("d_period%0d", i), n, 2);
        end
`ifdef DIV_CTRL_TICK_COUNT_EN
        chk("d_tcount10", tick_count, 10);
`endif
        stop = 1; step(); stop = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the divide value and period counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 2, divide value loaded at reset; legal range 1..2^CNT_W-1.
REQ-003 SHALL have clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have start  input  1  one-cycle request to begin ticking.
REQ-006 SHALL have stop  input  1  one-cycle request to halt ticking.
REQ-007 SHALL have cfg_valid  input  1  new divide value offered.
REQ-008 SHALL have cfg_div  input  CNT_W  offered divide value.
REQ-009 SHALL have cfg_ready  output  1  new divide value can be accepted.
REQ-010 SHALL have cfg_err  output  1  one-cycle pulse; zero divide value rejected.
REQ-011 SHALL have tick  output  1  registered one-cycle enable pulse, once per divide period.
REQ-012 SHALL have busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have div_active  output  CNT_W  divide value currently in force.

Function
REQ-014 SHALL implement states IDLE, RUN, PEND (RUN with a staged config waiting for period end).
REQ-015 Transfer SHALL occur on an edge where cfg_valid and cfg_ready are both high.
REQ-016 A transfer with cfg_div==0 SHALL be discarded, pulse cfg_err the next cycle and leave state and div_active unchanged.
REQ-017 IDLE: counter held at 0, tick 0, cfg_ready 1; a legal transfer SHALL update div_active at that edge.
REQ-018 IDLE + start (stop low) -> RUN with counter 0; if a legal transfer occurs on the same edge, the first period SHALL use the new value.
REQ-019 RUN: counter increments each cycle; on the edge where counter==div_active-1, tick SHALL go high for the following cycle and counter SHALL return to 0.
REQ-020 First tick SHALL be visible exactly div_active cycles after the edge that sampled start; with div_active==1, tick stays high every cycle in RUN/PEND.
REQ-021 RUN + legal transfer on a non-terminal cycle -> value staged, state PEND, cfg_ready 0 until applied.
REQ-022 RUN + legal transfer on the terminal-count cycle SHALL apply the value at that edge, remain in RUN, and the next period uses it.
REQ-023 PEND: on the terminal-count edge the staged value SHALL load into div_active, tick fires for the completing (old) period, state -> RUN.
REQ-024 stop in RUN or PEND -> IDLE at next edge, counter 0, no tick for the aborted period; any staged value SHALL be applied to div_active at that edge.
REQ-025 start and stop sampled together SHALL act as stop; start while RUN/PEND SHALL be ignored.
REQ-026 Counter arithmetic SHALL be CNT_W bits and never exceed div_active-1.

Reset
REQ-027 With reset_n low at an edge: state IDLE, counter 0, div_active=DEFAULT_DIV, staged value cleared, tick 0, cfg_err 0, busy 0, cfg_ready 1 (after release).
REQ-028 cfg_ready SHALL be 0 while reset_n is low; reset mid-period SHALL abort with no tick and discard any staged value.

Configuration
REQ-029 Macro DIV_CTRL_TICK_COUNT_EN SHALL, when defined, add output tick_count (32 bits): reset 0, increments by 1 on each tick, wraps 2^32-1 -> 0, cleared on start from IDLE.
REQ-030 Without DIV_CTRL_TICK_COUNT_EN the port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset, DEFAULT_DIV=2, start -> tick on cycles 2,4,6... after start; busy 1; div_active=2.
REQ-032 RUN with div 5, transfer div 3 at counter 1 -> cfg_ready 0, ticks 5 cycles apart until the next tick, then 3 apart; div_active=3 after that tick.
REQ-033 Transfer cfg_div=0 in IDLE and RUN -> cfg_err single pulse, div_active unchanged, tick spacing unchanged.
REQ-034 div 1 -> tick continuously high while RUN; stop -> tick 0 and busy 0 next cycle.
REQ-035 Stop while PEND holding div 7 -> IDLE, no tick, div_active=7; start -> first tick 7 cycles later.
REQ-036 reset_n low mid-period with div 4 and staged 9 -> all outputs at reset values, div_active=2; with DIV_CTRL_TICK_COUNT_EN, tick_count=0 and counts 10 ticks to 10.
